board_ram_ctrl: RTL

- Owns one player's 10x10 board: the 2-bit tile-status store read by the video subsystem on us_ram/them_ram.
- Executes game-logic commands against the board: clear, place ship, fire shot.
- Returns a one-cycle result for each command and tracks the number of unhit ship cells.
- Two instances exist: one per board. The display-side port is read-only and never stalls.

---
 rtl/board_ram_ctrl.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/board_ram_ctrl.sv
// board_ram_ctrl: one player's 10x10 tile store, with a command FSM for
// clear / place / fire and a display read port that never stalls.
module board_ram_ctrl #(
   parameter int GRID    = 10,
   parameter int MAX_LEN = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [9:0] rd_addr,
   output logic [1:0] rd_data,
   input  logic       cmd_valid,
   output logic       cmd_ready,
   input  logic [1:0] cmd_op,
   input  logic [7:0] cmd_pos,
   input  logic [2:0] cmd_len,
   input  logic       cmd_vert,
   output logic       rsp_valid,
   output logic [1:0] rsp_code,
   output logic [4:0] ship_cells,
   output logic       all_sunk
);

   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_CLR  = 3'd1;
   localparam logic [2:0] ST_DEC  = 3'd2;
   localparam logic [2:0] ST_CHK  = 3'd3;
   localparam logic [2:0] ST_WR   = 3'd4;
   localparam logic [2:0] ST_FIRE = 3'd5;
   localparam logic [2:0] ST_RSP  = 3'd6;

   localparam logic [1:0] T_EMPTY = 2'd0;
   localparam logic [1:0] T_MISS  = 2'd1;
   localparam logic [1:0] T_HIT   = 2'd2;
   localparam logic [1:0] T_SHIP  = 2'd3;

   localparam logic [1:0] C_OK  = 2'd0;
   localparam logic [1:0] C_MIS = 2'd1;
   localparam logic [1:0] C_HIT = 2'd2;
   localparam logic [1:0] C_REJ = 2'd3;

   localparam logic [4:0] GRID_W = 5'(GRID);
   localparam logic [3:0] MAXL_W = 4'(MAX_LEN);

   logic [1:0] r_mem [256];
   logic [2:0] r_state;
   logic [7:0] r_k;
   logic [7:0] r_pos;
   logic [2:0] r_len;
   logic       r_vert;
   logic [1:0] r_code;
   logic [4:0] r_ships;
   logic       r_placed;
   logic       r_boot;
   logic [1:0] r_rd;

   logic [3:0] w_x;
   logic [3:0] w_y;
   logic       w_in_range;
   logic [4:0] w_end;
   logic       w_bad;
   logic [7:0] w_cell;
   logic [7:0] w_raddr;
   logic [1:0] w_tile;
   logic       w_klast;
   logic [5:0] w_sum;
   logic       w_fire_mis;
   logic       w_fire_hit;
   logic       w_we;
   logic [7:0] w_waddr;
   logic [1:0] w_wdata;
   logic       w_unused;

   assign w_unused   = ^rd_addr[9:8];
   assign w_x        = r_pos[7:4];
   assign w_y        = r_pos[3:0];
   assign w_in_range = ({1'b0, w_x} < GRID_W) && ({1'b0, w_y} < GRID_W);
   assign w_end      = (r_vert ? {1'b0, w_y} : {1'b0, w_x})
                     + {2'b00, r_len} - 5'd1;
   assign w_bad      = (r_len == 3'd0) || ({1'b0, r_len} > MAXL_W)
                     || !w_in_range || (w_end >= GRID_W);
   assign w_cell     = r_vert ? {w_x, w_y + r_k[3:0]}
                              : {w_x + r_k[3:0], w_y};
   assign w_raddr    = (r_state == ST_FIRE) ? r_pos : w_cell;
   assign w_tile     = r_mem[w_raddr];
   assign w_klast    = (r_k[2:0] == r_len - 3'd1);
   assign w_sum      = {1'b0, r_ships} + {3'b000, r_len};
   assign w_fire_mis = (r_state == ST_FIRE) && w_in_range
                     && (w_tile == T_EMPTY);
   assign w_fire_hit = (r_state == ST_FIRE) && w_in_range
                     && (w_tile == T_SHIP);

   always_comb begin
      w_we    = 1'b0;
      w_waddr = r_k;
      w_wdata = T_EMPTY;
      if (r_state == ST_CLR) begin
         w_we = 1'b1;
      end else if (r_state == ST_WR) begin
         w_we    = 1'b1;
         w_waddr = w_cell;
         w_wdata = T_SHIP;
      end else if (w_fire_mis || w_fire_hit) begin
         w_we    = 1'b1;
         w_waddr = r_pos;
         w_wdata = w_fire_hit ? T_HIT : T_MISS;
      end
   end

   // No reset on the array: the boot-time CLR sweep initialises it.
   always_ff @(posedge clk) begin
      if (w_we) r_mem[w_waddr] <= w_wdata;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state  <= ST_CLR;
         r_k      <= 8'd0;
         r_pos    <= 8'd0;
         r_len    <= 3'd0;
         r_vert   <= 1'b0;
         r_code   <= C_OK;
         r_ships  <= 5'd0;
         r_placed <= 1'b0;
         r_boot   <= 1'b1;
         r_rd     <= T_EMPTY;
      end else begin
         r_rd <= r_mem[rd_addr[7:0]];
         case (r_state)
            ST_IDLE: begin
               if (cmd_valid) begin
                  r_pos  <= cmd_pos;
                  r_len  <= cmd_len;
                  r_vert <= cmd_vert;
                  r_k    <= 8'd0;
                  case (cmd_op)
                     2'd0:    r_state <= ST_CLR;
                     2'd1:    r_state <= ST_DEC;
                     2'd2:    r_state <= ST_FIRE;
                     default: begin
                        r_code  <= C_REJ;
                        r_state <= ST_RSP;
                     end
                  endcase
               end
            end
            ST_CLR: begin
               r_k <= r_k + 8'd1;
               if (r_k == 8'hFF) begin
                  r_ships  <= 5'd0;
                  r_placed <= 1'b0;
                  r_boot   <= 1'b0;
                  r_code   <= C_OK;
                  r_state  <= r_boot ? ST_IDLE : ST_RSP;
               end
            end
            ST_DEC: begin
               r_k <= 8'd0;
               if (w_bad) begin
                  r_code  <= C_REJ;
                  r_state <= ST_RSP;
               end else begin
                  r_state <= ST_CHK;
               end
            end
            ST_CHK: begin
               if (w_tile != T_EMPTY) begin
                  r_code  <= C_REJ;
                  r_state <= ST_RSP;
               end else if (w_klast) begin
                  r_k     <= 8'd0;
                  r_state <= ST_WR;
               end else begin
                  r_k <= r_k + 8'd1;
               end
            end
            ST_WR: begin
               r_k <= r_k + 8'd1;
               if (w_klast) begin
                  r_ships  <= w_sum[5] ? 5'd31 : w_sum[4:0];
                  r_placed <= 1'b1;
                  r_code   <= C_OK;
                  r_state  <= ST_RSP;
               end
            end
            ST_FIRE: begin
               r_state <= ST_RSP;
               if (w_fire_mis) begin
                  r_code <= C_MIS;
               end else if (w_fire_hit) begin
                  r_code <= C_HIT;
                  if (r_ships != 5'd0) r_ships <= r_ships - 5'd1;
               end else begin
                  r_code <= C_REJ;
               end
            end
            ST_RSP:  r_state <= ST_IDLE;
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign rd_data    = r_rd;
   assign cmd_ready  = (r_state == ST_IDLE);
   assign rsp_valid  = (r_state == ST_RSP);
   assign rsp_code   = r_code;
   assign ship_cells = r_ships;
   assign all_sunk   = r_placed && (r_ships == 5'd0);

endmodule
